// File: rtl/fpga_bl_wl_config_ctrl_if.sv
// -----------------------------------------------------------------------------
// fpga_bl_wl_config_ctrl_if
//   Bitstream-side bus of the BL/WL configuration controller.
//   start      : 1-cycle pulse that kicks off a programming pass
//   cfg_data   : bitstream word (DATA_W bits)
//   cfg_valid  : cfg_data is valid
//   cfg_ready  : controller accepts a word; a word moves when valid & ready
//   master modport = bitstream source, slave modport = controller.
// -----------------------------------------------------------------------------
interface fpga_bl_wl_config_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output start,
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  start,
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/fpga_bl_wl_config_ctrl.sv
// -----------------------------------------------------------------------------
// fpga_bl_wl_config_ctrl
//   Programs the fabric memory-bank configuration array one word-line row at a
//   time. The BL data of a row is assembled from WPR = ceil(BL_WIDTH/DATA_W)
//   bitstream words, then the row's WL line is strobed for WL_PULSE_CYC cycles.
//   After the last row the fabric reset (global_resetn) is released
//   RESETN_DELAY cycles after the last HOLD cycle.
//
// Optional feature (compile-time macro CFG_CRC_EN):
//   A CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) runs over every
//   accepted data word. After the last row one trailer word is accepted;
//   trailer[15:0] must equal the CRC or the controller stops in ERR.
//   Without the macro there is no trailer and o_error is tied low.
//
// Ports
//   i_clk           configuration clock
//   i_rst           asynchronous, active-high reset
//   bus             slave side of fpga_bl_wl_config_ctrl_if (start/data/valid/ready)
//   o_bl            bit-line data, bit k*DATA_W+i takes cfg_data[i] of word k
//   o_wl            word-line strobes, one-hot or zero
//   o_fabric_resetn fabric global_resetn
//   o_busy          programming in progress
//   o_done          programming finished, fabric released
//   o_error         trailer CRC mismatch (sticky until the next start)
//   o_row_idx       row currently being programmed
// -----------------------------------------------------------------------------
module fpga_bl_wl_config_ctrl #(
    parameter int BL_WIDTH     = 514,
    parameter int WL_WIDTH     = 407,
    parameter int DATA_W       = 32,
    parameter int WL_PULSE_CYC = 2,
    parameter int RESETN_DELAY = 4,
    localparam int ROW_W       = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    fpga_bl_wl_config_ctrl_if.slave bus,
    output logic [BL_WIDTH-1:0]     o_bl,
    output logic [WL_WIDTH-1:0]     o_wl,
    output logic                    o_fabric_resetn,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [ROW_W-1:0]        o_row_idx
);

    localparam int WPR  = (BL_WIDTH + DATA_W - 1) / DATA_W;
    localparam int WC_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int PC_W = (WL_PULSE_CYC > 1) ? $clog2(WL_PULSE_CYC) : 1;
    localparam int DC_W = (RESETN_DELAY > 1) ? $clog2(RESETN_DELAY) : 1;

    localparam logic [WL_WIDTH-1:0] WL_ONE = WL_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PULSE,
        ST_HOLD,
        ST_CHECK,
        ST_RELEASE,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t              r_state;
    logic [BL_WIDTH-1:0] r_bl;
    logic [WL_WIDTH-1:0] r_wl;
    logic                r_cfg_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_fabric_resetn;
    logic [ROW_W-1:0]    r_row_idx;
    logic [WC_W-1:0]     r_word_cnt;
    logic [PC_W-1:0]     r_pulse_cnt;
    logic [DC_W-1:0]     r_delay_cnt;

    logic                w_accept;
    logic                w_start_ok;
    logic                w_last_word;
    logic                w_last_row;
    logic [WPR-1:0]      w_word_wr;
    logic [BL_WIDTH-1:0] w_bl_next;

    // A word is only taken in LOAD; the trailer in CHECK is handled separately
    // so that it never lands in the BL register.
    assign w_accept    = (r_state == ST_LOAD) && bus.cfg_valid && r_cfg_ready;
    // start is honoured only when nothing is in flight
    assign w_start_ok  = bus.start &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_last_word = (r_word_cnt == WC_W'(WPR - 1));
    assign w_last_row  = (r_row_idx == ROW_W'(WL_WIDTH - 1));

    // Per-word BL slice update. The last word of a row may be only partly
    // used: its slice is clipped at BL_WIDTH and the upper data bits dropped.
    genvar gi;
    generate
        for (gi = 0; gi < WPR; gi++) begin : g_word
            localparam int LO = gi * DATA_W;
            localparam int HI = ((LO + DATA_W) > BL_WIDTH) ? (BL_WIDTH - 1) : (LO + DATA_W - 1);
            localparam int SW = HI - LO + 1;

            assign w_word_wr[gi]   = w_accept && (r_word_cnt == WC_W'(gi));
            assign w_bl_next[HI:LO] = w_word_wr[gi] ? bus.cfg_data[SW-1:0] : r_bl[HI:LO];
        end
    endgenerate

`ifdef CFG_CRC_EN
    logic [15:0] r_crc;
    logic        r_error;
    logic [15:0] w_crc_next;
    logic        w_trailer_ok;

    // Bit-serial CRC-16-CCITT over one word, most significant bit first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [DATA_W-1:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign w_crc_next   = crc16_word(r_crc, bus.cfg_data);
    assign w_trailer_ok = (bus.cfg_data[15:0] == r_crc);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_bl            <= '0;
            r_wl            <= '0;
            r_cfg_ready     <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_fabric_resetn <= 1'b0;
            r_row_idx       <= '0;
            r_word_cnt      <= '0;
            r_pulse_cnt     <= '0;
            r_delay_cnt     <= '0;
`ifdef CFG_CRC_EN
            r_crc           <= 16'hFFFF;
            r_error         <= 1'b0;
`endif
        end else begin
            r_bl <= w_bl_next;

            if (w_start_ok) begin
                // Fresh pass: fabric goes back into reset and row 0 loads next.
                r_state         <= ST_LOAD;
                r_cfg_ready     <= 1'b1;
                r_busy          <= 1'b1;
                r_done          <= 1'b0;
                r_fabric_resetn <= 1'b0;
                r_row_idx       <= '0;
                r_word_cnt      <= '0;
                r_pulse_cnt     <= '0;
                r_delay_cnt     <= '0;
`ifdef CFG_CRC_EN
                r_crc           <= 16'hFFFF;
                r_error         <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_accept) begin
`ifdef CFG_CRC_EN
                            r_crc <= w_crc_next;
`endif
                            if (w_last_word) begin
                                // Ready drops in the same edge that raises WL,
                                // so the two never overlap.
                                r_word_cnt  <= '0;
                                r_cfg_ready <= 1'b0;
                                r_wl        <= WL_ONE << r_row_idx;
                                r_pulse_cnt <= '0;
                                r_state     <= ST_PULSE;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end
                    end

                    ST_PULSE: begin
                        if (r_pulse_cnt == PC_W'(WL_PULSE_CYC - 1)) begin
                            r_wl    <= '0;
                            r_state <= ST_HOLD;
                        end else begin
                            r_pulse_cnt <= r_pulse_cnt + 1'b1;
                        end
                    end

                    ST_HOLD: begin
                        if (!w_last_row) begin
                            r_row_idx   <= r_row_idx + 1'b1;
                            r_cfg_ready <= 1'b1;
                            r_state     <= ST_LOAD;
                        end else begin
`ifdef CFG_CRC_EN
                            r_cfg_ready <= 1'b1;
                            r_state     <= ST_CHECK;
`else
                            r_delay_cnt <= '0;
                            r_state     <= ST_RELEASE;
`endif
                        end
                    end

`ifdef CFG_CRC_EN
                    ST_CHECK: begin
                        if (bus.cfg_valid && r_cfg_ready) begin
                            r_cfg_ready <= 1'b0;
                            if (w_trailer_ok) begin
                                r_delay_cnt <= '0;
                                r_state     <= ST_RELEASE;
                            end else begin
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_ERR;
                            end
                        end
                    end
`endif

                    ST_RELEASE: begin
                        if (r_delay_cnt == DC_W'(RESETN_DELAY - 1)) begin
                            r_fabric_resetn <= 1'b1;
                            r_done          <= 1'b1;
                            r_busy          <= 1'b0;
                            r_state         <= ST_DONE;
                        end else begin
                            r_delay_cnt <= r_delay_cnt + 1'b1;
                        end
                    end

                    ST_IDLE, ST_DONE, ST_ERR: begin
                        // outputs held; only start leaves these states
                    end

                    default: begin
                        r_wl        <= '0;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cfg_ready   = r_cfg_ready;
    assign o_bl            = r_bl;
    assign o_wl            = r_wl;
    assign o_fabric_resetn = r_fabric_resetn;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_row_idx       = r_row_idx;
`ifdef CFG_CRC_EN
    assign o_error         = r_error;
`else
    assign o_error         = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_bl_wl_config_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpga_bl_wl_config_ctrl
//   Self-checking bench for fpga_bl_wl_config_ctrl with BL_WIDTH=40,
//   WL_WIDTH=3, DATA_W=16, WL_PULSE_CYC=2, RESETN_DELAY=4.
//   Inputs are driven 1 ns after the rising edge, outputs sampled on the
//   falling edge. Expected BL rows are rebuilt from the word list that was
//   sent; the monitor follows rows by observing WL pulses.
//   Build with +define+CFG_CRC_EN to exercise the trailer check.
// -----------------------------------------------------------------------------
module tb_fpga_bl_wl_config_ctrl;

    localparam int BLW   = 40;
    localparam int WLW   = 3;
    localparam int DW    = 16;
    localparam int PULSE = 2;
    localparam int RDLY  = 4;
    localparam int WPR   = (BLW + DW - 1) / DW;
    localparam int NW    = WPR * WLW;
    localparam int RW    = 2;

    typedef logic [DW-1:0] word_q_t[$];

    logic           clk = 1'b0;
    logic           rst;
    logic [BLW-1:0] bl;
    logic [WLW-1:0] wl;
    logic           fabric_resetn;
    logic           busy;
    logic           done;
    logic           error;
    logic [RW-1:0]  row_idx;

    always #5 clk = ~clk;

    fpga_bl_wl_config_ctrl_if #(.DATA_W(DW)) bus_if ();

    fpga_bl_wl_config_ctrl #(
        .BL_WIDTH    (BLW),
        .WL_WIDTH    (WLW),
        .DATA_W      (DW),
        .WL_PULSE_CYC(PULSE),
        .RESETN_DELAY(RDLY)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .bus            (bus_if),
        .o_bl           (bl),
        .o_wl           (wl),
        .o_fabric_resetn(fabric_resetn),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error),
        .o_row_idx      (row_idx)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_words [NW];

    // Row r uses words r*WPR .. r*WPR+WPR-1; bit b comes from word b/DW, bit b%DW.
    function automatic logic [BLW-1:0] model_bl(input int row);
        logic [BLW-1:0] r;
        for (int b = 0; b < BLW; b++) r[b] = exp_words[row * WPR + b / DW][b % DW];
        return r;
    endfunction

    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int w = 0; w < NW; w++) begin
            for (int i = DW - 1; i >= 0; i--) begin
                fb = c[15] ^ exp_words[w][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic word_q_t build_q(input bit corrupt);
        word_q_t q;
        for (int i = 0; i < NW; i++) q.push_back(exp_words[i]);
`ifdef CFG_CRC_EN
        q.push_back(model_crc() ^ (corrupt ? 16'h0001 : 16'h0000));
`else
        if (corrupt) q.push_back('0);
`endif
        return q;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NW; i++) exp_words[i] = DW'($urandom);
    endtask

    // ---------------- monitor ----------------
    int          cyc        = 0;
    int          mon_row    = 0;
    int          pulse_len  = 0;
    int          hold_cyc   = 0;
    int          last_rise  = -1;
    bit          b2b_mode   = 1'b0;
    logic [WLW-1:0] prev_wl = '0;
    logic        prev_done  = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_row   = 0;
            pulse_len = 0;
            last_rise = -1;
            prev_wl   = '0;
            prev_done = 1'b0;
        end else begin
            if (bus_if.start && !busy) begin
                mon_row   = 0;
                last_rise = -1;
            end
            if (wl != '0) begin
                check("ready_with_wl", bus_if.cfg_ready, 1'b0);
                check("wl_onehot", wl, WLW'(1) << mon_row);
                if (mon_row < WLW) check("bl_row", bl, model_bl(mon_row));
                if (prev_wl == '0) begin
                    check("row_idx", row_idx, mon_row);
                    if (b2b_mode && last_rise >= 0) check("row_period", cyc - last_rise, WPR + PULSE + 1);
                    last_rise = cyc;
                    $display("row %0d wl=%b bl=%h", mon_row, wl, bl);
                end
                pulse_len++;
            end else if (prev_wl != '0) begin
                check("pulse_len", pulse_len, PULSE);
                pulse_len = 0;
                if (mon_row < WLW) check("hold_bl", bl, model_bl(mon_row));
                if (mon_row == WLW - 1) hold_cyc = cyc;
                mon_row++;
            end
            if (done && !prev_done) begin
                check("resetn_at_done", fabric_resetn, 1'b1);
                check("rows_at_done", mon_row, WLW);
`ifndef CFG_CRC_EN
                check("done_delay", cyc - hold_cyc, RDLY + 1);
`endif
            end
            prev_wl   = wl;
            prev_done = done;
        end
    end

    // ---------------- drivers ----------------
    bit abort_drv = 1'b0;

    task automatic pulse_start();
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic drive_words(input word_q_t words, input int gap_max);
        int idx;
        int gap;
        int budget;
        idx    = 0;
        budget = 2000;
        gap    = $urandom_range(gap_max, 0);
        while (idx < words.size() && !abort_drv) begin
            @(posedge clk); #1;
            budget--;
            if (budget == 0) begin
                check("drv_timeout", idx, words.size());
                break;
            end
            if (gap > 0) begin
                bus_if.cfg_valid = 1'b0;
                bus_if.cfg_data  = DW'($urandom);
                gap--;
            end else begin
                bus_if.cfg_valid = 1'b1;
                bus_if.cfg_data  = words[idx];
                // ready is stable for this cycle, so the coming edge takes the word
                if (bus_if.cfg_ready) begin
                    idx++;
                    gap = $urandom_range(gap_max, 0);
                end
            end
        end
        @(posedge clk); #1;
        bus_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        @(negedge clk);
        while (!(done || error) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("end_timeout", 0, 1);
    endtask

    task automatic run_pass(input int gap_max, input bit corrupt);
        pulse_start();
        drive_words(build_q(corrupt), gap_max);
        wait_end();
        $display("pass end: done=%0b error=%0b resetn=%0b", done, error, fabric_resetn);
    endtask

    task automatic check_done_state(input string tag);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_resetn"}, fabric_resetn, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_ready"}, bus_if.cfg_ready, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end, expected finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        rst              = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bl", bl, '0);
        check("rst_wl", wl, '0);
        check("rst_resetn", fabric_resetn, 1'b0);
        check("rst_ready", bus_if.cfg_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_row", row_idx, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: back-to-back words
        fill_random();
        b2b_mode = 1'b1;
        run_pass(0, 1'b0);
        b2b_mode = 1'b0;
        check_done_state("t1");

        // 2: random valid gaps
        fill_random();
        run_pass(3, 1'b0);
        check_done_state("t2");

        // 3: start during row 1 is ignored
        fill_random();
        pulse_start();
        fork
            drive_words(build_q(1'b0), 1);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!(row_idx == RW'(1) && bus_if.cfg_ready) && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 300) check("t3_wait_row1", 0, 1);
                pulse_start();
            end
        join
        wait_end();
        check_done_state("t3");
        check("t3_final_row", row_idx, WLW - 1);

        // 6: start from DONE restarts
        fill_random();
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        @(negedge clk);
        check("t6_resetn_fall", fabric_resetn, 1'b0);
        check("t6_done_fall", done, 1'b0);
        check("t6_busy", busy, 1'b1);
        drive_words(build_q(1'b0), 2);
        wait_end();
        check_done_state("t6");

        // 4: reset while row 1 is strobed
        fill_random();
        pulse_start();
        fork
            drive_words(build_q(1'b0), 0);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (wl != 3'b010 && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 300) check("t4_wait_wl", 0, 1);
                #1;
                abort_drv = 1'b1;
                rst       = 1'b1;
                #1;
                check("t4_wl", wl, '0);
                check("t4_resetn", fabric_resetn, 1'b0);
                check("t4_busy", busy, 1'b0);
                check("t4_row", row_idx, '0);
            end
        join
        @(posedge clk); #1;
        rst       = 1'b0;
        abort_drv = 1'b0;
        fill_random();
        run_pass(1, 1'b0);
        check_done_state("t4");

`ifdef CFG_CRC_EN
        // 5: CRC trailer
        for (int i = 0; i < NW; i++) exp_words[i] = DW'(i + 1);
        run_pass(0, 1'b0);
        check_done_state("t5_good");
        run_pass(1, 1'b1);
        check("t5_err", error, 1'b1);
        check("t5_err_resetn", fabric_resetn, 1'b0);
        check("t5_err_done", done, 1'b0);
        check("t5_err_busy", busy, 1'b0);
        pulse_start();
        @(negedge clk);
        check("t5_err_clear", error, 1'b0);
        drive_words(build_q(1'b0), 0);
        wait_end();
        check_done_state("t5_retry");
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
